mag_peak_detect: RTL and testbench

MAG_PEAK_DETECT -- requirements
Module: mag_peak_detect

---
 rtl/mag_peak_pkg.sv | 14 +
 rtl/mag_peak_detect.sv | 159 +++++++++++++++
 tb/tb_mag_peak_detect.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mag_peak_pkg.sv
// mag_peak_pkg: shared FSM state type and default widths for the peak detector
package mag_peak_pkg;

    localparam int unsigned MAG_LEN   = 64;
    localparam int unsigned INDEX_LEN = 32;
    localparam int unsigned TUSER_LEN = 32;
    localparam int unsigned CNT_LEN   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/mag_peak_detect.sv
// mag_peak_detect: per-frame peak search over a magnitude-squared sample stream
//
// Ports:
//   clk, aresetn          clock and asynchronous active-low reset
//   mag_sq/mag_tvalid     sample and valid (no backpressure)
//   mag_tlast             last sample of a frame (qualified by mag_tvalid)
//   mag_tuser             frame tag captured on the first sample of a frame
//   mag_index             index of the sample
//   mag_overflow          upstream overflow flag, OR-accumulated per frame
//   peak_*                registered frame result, stable until the next peak_valid
//   peak_valid            one-cycle strobe, one cycle after the tlast sample
//
// Build option MAG_PEAK_THRESHOLD_EN adds input threshold and output above_count
// (saturating per-frame count of samples strictly above threshold).
module mag_peak_detect #(
    parameter int MAG_LEN   = mag_peak_pkg::MAG_LEN,
    parameter int TUSER_LEN = mag_peak_pkg::TUSER_LEN,
    parameter int INDEX_LEN = mag_peak_pkg::INDEX_LEN,
    parameter int CNT_LEN   = mag_peak_pkg::CNT_LEN
) (
    input  logic                 clk,
    input  logic                 aresetn,
`ifdef MAG_PEAK_THRESHOLD_EN
    input  logic [MAG_LEN-1:0]   threshold,
    output logic [CNT_LEN-1:0]   above_count,
`endif
    input  logic [MAG_LEN-1:0]   mag_sq,
    input  logic                 mag_tvalid,
    input  logic                 mag_tlast,
    input  logic [TUSER_LEN-1:0] mag_tuser,
    input  logic [INDEX_LEN-1:0] mag_index,
    input  logic                 mag_overflow,
    output logic [MAG_LEN-1:0]   peak_mag,
    output logic [INDEX_LEN-1:0] peak_index,
    output logic [TUSER_LEN-1:0] peak_tuser,
    output logic [CNT_LEN-1:0]   peak_count,
    output logic                 peak_overflow,
    output logic                 peak_valid
);
    import mag_peak_pkg::*;

    state_e                 state_q, state_d;
    logic [MAG_LEN-1:0]     run_mag_q, run_mag_d;
    logic [INDEX_LEN-1:0]   run_idx_q, run_idx_d;
    logic [TUSER_LEN-1:0]   run_tuser_q, run_tuser_d;
    logic [CNT_LEN-1:0]     run_cnt_q, run_cnt_d;
    logic                   run_ovf_q, run_ovf_d;
    logic [MAG_LEN-1:0]     peak_mag_q, peak_mag_d;
    logic [INDEX_LEN-1:0]   peak_idx_q, peak_idx_d;
    logic [TUSER_LEN-1:0]   peak_tuser_q, peak_tuser_d;
    logic [CNT_LEN-1:0]     peak_cnt_q, peak_cnt_d;
    logic                   peak_ovf_q, peak_ovf_d;
    logic                   peak_valid_q, peak_valid_d;
    logic                   first;
    logic                   take;
    logic                   done;

    // Every frame ends by returning to IDLE, so IDLE always means "next valid
    // sample opens a frame", including the cycle right after a tlast.
    assign first = (state_q == IDLE);
    // Strict compare keeps the earliest index on ties.
    assign take  = first || (mag_sq > run_mag_q);
    assign done  = mag_tvalid && mag_tlast;

    always_comb begin
        state_d      = state_q;
        run_mag_d    = run_mag_q;
        run_idx_d    = run_idx_q;
        run_tuser_d  = run_tuser_q;
        run_cnt_d    = run_cnt_q;
        run_ovf_d    = run_ovf_q;
        if (mag_tvalid) begin
            state_d     = mag_tlast ? IDLE : ACCUM;
            run_mag_d   = take ? mag_sq : run_mag_q;
            run_idx_d   = take ? mag_index : run_idx_q;
            run_tuser_d = first ? mag_tuser : run_tuser_q;
            run_cnt_d   = first ? CNT_LEN'(1)
                        : (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNT_LEN'(1);
            run_ovf_d   = first ? mag_overflow : (run_ovf_q | mag_overflow);
        end
    end

    // Result registers load the running state including the tlast sample.
    always_comb begin
        peak_valid_d = done;
        peak_mag_d   = done ? run_mag_d   : peak_mag_q;
        peak_idx_d   = done ? run_idx_d   : peak_idx_q;
        peak_tuser_d = done ? run_tuser_d : peak_tuser_q;
        peak_cnt_d   = done ? run_cnt_d   : peak_cnt_q;
        peak_ovf_d   = done ? run_ovf_d   : peak_ovf_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            run_mag_q    <= '0;
            run_idx_q    <= '0;
            run_tuser_q  <= '0;
            run_cnt_q    <= '0;
            run_ovf_q    <= 1'b0;
            peak_mag_q   <= '0;
            peak_idx_q   <= '0;
            peak_tuser_q <= '0;
            peak_cnt_q   <= '0;
            peak_ovf_q   <= 1'b0;
            peak_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_mag_q    <= run_mag_d;
            run_idx_q    <= run_idx_d;
            run_tuser_q  <= run_tuser_d;
            run_cnt_q    <= run_cnt_d;
            run_ovf_q    <= run_ovf_d;
            peak_mag_q   <= peak_mag_d;
            peak_idx_q   <= peak_idx_d;
            peak_tuser_q <= peak_tuser_d;
            peak_cnt_q   <= peak_cnt_d;
            peak_ovf_q   <= peak_ovf_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_mag      = peak_mag_q;
    assign peak_index    = peak_idx_q;
    assign peak_tuser    = peak_tuser_q;
    assign peak_count    = peak_cnt_q;
    assign peak_overflow = peak_ovf_q;
    assign peak_valid    = peak_valid_q;

`ifdef MAG_PEAK_THRESHOLD_EN
    logic                   hit;
    logic [CNT_LEN-1:0]     run_above_q, run_above_d;
    logic [CNT_LEN-1:0]     above_q, above_d;

    assign hit = mag_sq > threshold;

    always_comb begin
        run_above_d = run_above_q;
        if (mag_tvalid) begin
            run_above_d = first ? CNT_LEN'(hit)
                        : (hit && !(&run_above_q)) ? run_above_q + CNT_LEN'(1) : run_above_q;
        end
        above_d = done ? run_above_d : above_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            run_above_q <= '0;
            above_q     <= '0;
        end else begin
            run_above_q <= run_above_d;
            above_q     <= above_d;
        end
    end

    assign above_count = above_q;
`endif

endmodule

// File: tb/tb_mag_peak_detect.sv
// tb_mag_peak_detect: directed self-checking bench for mag_peak_detect
module tb_mag_peak_detect;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] mag_sq = '0;
    logic        mag_tvalid = 1'b0;
    logic        mag_tlast = 1'b0;
    logic [31:0] mag_tuser = '0;
    logic [31:0] mag_index = '0;
    logic        mag_overflow = 1'b0;
    logic [63:0] peak_mag;
    logic [31:0] peak_index;
    logic [31:0] peak_tuser;
    logic [15:0] peak_count;
    logic        peak_overflow;
    logic        peak_valid;
`ifdef MAG_PEAK_THRESHOLD_EN
    logic [63:0] threshold = '0;
    logic [15:0] above_count;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int pv_cnt = 0;
    int base;

    mag_peak_detect dut (
        .clk          (clk),
        .aresetn      (aresetn),
`ifdef MAG_PEAK_THRESHOLD_EN
        .threshold    (threshold),
        .above_count  (above_count),
`endif
        .mag_sq       (mag_sq),
        .mag_tvalid   (mag_tvalid),
        .mag_tlast    (mag_tlast),
        .mag_tuser    (mag_tuser),
        .mag_index    (mag_index),
        .mag_overflow (mag_overflow),
        .peak_mag     (peak_mag),
        .peak_index   (peak_index),
        .peak_tuser   (peak_tuser),
        .peak_count   (peak_count),
        .peak_overflow(peak_overflow),
        .peak_valid   (peak_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (peak_valid) pv_cnt++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic last, input logic [63:0] m,
                         input logic [31:0] idx, input logic [31:0] tu, input logic ov);
        @(negedge clk);
        mag_tvalid   = v;
        mag_tlast    = last;
        mag_sq       = m;
        mag_index    = idx;
        mag_tuser    = tu;
        mag_overflow = ov;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'hDEAD, 32'hFF, 32'hEE, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_mag",   peak_mag, 0);
        check("rst_valid", {63'd0, peak_valid}, 0);
        check("rst_count", {48'd0, peak_count}, 0);
        check("rst_ovf",   {63'd0, peak_overflow}, 0);
        @(negedge clk) aresetn = 1'b1;

        // frame 5,9,3,9: tie on 9 keeps index 1
        drive(1, 0, 5, 0, 32'h11, 0);
        drive(1, 0, 9, 1, 32'h22, 0);
        drive(1, 0, 3, 2, 32'h33, 0);
        drive(1, 1, 9, 3, 32'h44, 0);
        idle();
        check("f1_valid", {63'd0, peak_valid}, 1);
        check("f1_mag",   peak_mag, 9);
        check("f1_index", {32'd0, peak_index}, 1);
        check("f1_count", {48'd0, peak_count}, 4);
        check("f1_tuser", {32'd0, peak_tuser}, 32'h11);
        check("f1_ovf",   {63'd0, peak_overflow}, 0);
        idle();
        check("f1_pulse_end", {63'd0, peak_valid}, 0);
        check("f1_hold_mag",  peak_mag, 9);

        // single-sample frame in IDLE
        drive(1, 1, 64'h20, 7, 32'hA5, 0);
        idle();
        check("f2_valid", {63'd0, peak_valid}, 1);
        check("f2_mag",   peak_mag, 64'h20);
        check("f2_count", {48'd0, peak_count}, 1);
        check("f2_tuser", {32'd0, peak_tuser}, 32'hA5);
        check("f2_index", {32'd0, peak_index}, 7);

        // back-to-back frames [1,7] then [4]
        idle();
        base = pv_cnt;
        drive(1, 0, 1, 0, 32'h1, 0);
        drive(1, 1, 7, 1, 32'h9, 0);
        drive(1, 1, 4, 0, 32'h2, 0);
        check("bb1_valid", {63'd0, peak_valid}, 1);
        check("bb1_mag",   peak_mag, 7);
        check("bb1_count", {48'd0, peak_count}, 2);
        check("bb1_tuser", {32'd0, peak_tuser}, 1);
        idle();
        check("bb2_valid", {63'd0, peak_valid}, 1);
        check("bb2_mag",   peak_mag, 4);
        check("bb2_count", {48'd0, peak_count}, 1);
        check("bb2_tuser", {32'd0, peak_tuser}, 2);
        idle();
        check("bb_pulses", 64'(pv_cnt - base), 2);

        // reset mid-frame, then frame [2,3]
        base = pv_cnt;
        drive(1, 0, 8, 0, 32'h5, 0);
        drive(1, 0, 9, 1, 32'h5, 1);
        @(negedge clk);
        aresetn    = 1'b0;
        mag_tvalid = 1'b0;
        mag_tlast  = 1'b0;
        @(negedge clk);
        check("ar_rst_mag",   peak_mag, 0);
        check("ar_rst_count", {48'd0, peak_count}, 0);
        aresetn = 1'b1;
        drive(1, 0, 2, 0, 32'h6, 0);
        drive(1, 1, 3, 1, 32'h6, 0);
        idle();
        check("ar_valid", {63'd0, peak_valid}, 1);
        check("ar_mag",   peak_mag, 3);
        check("ar_count", {48'd0, peak_count}, 2);
        check("ar_index", {32'd0, peak_index}, 1);
        check("ar_ovf",   {63'd0, peak_overflow}, 0);
        idle();
        check("ar_pulses", 64'(pv_cnt - base), 1);

        // gaps, stray tlast without tvalid, overflow on 2nd sample only
        drive(1, 0, 4, 0, 32'h7, 0);
        idle();
        drive(1, 0, 6, 1, 32'h7, 1);
        drive(0, 1, 99, 9, 32'h7, 0);
        idle();
        check("gap_no_valid", {63'd0, peak_valid}, 0);
        drive(1, 1, 2, 2, 32'h7, 0);
        idle();
        check("gap_valid", {63'd0, peak_valid}, 1);
        check("gap_ovf",   {63'd0, peak_overflow}, 1);
        check("gap_count", {48'd0, peak_count}, 3);
        check("gap_mag",   peak_mag, 6);
        check("gap_index", {32'd0, peak_index}, 1);
        drive(1, 1, 1, 0, 32'h8, 0);
        idle();
        check("ovf_clear", {63'd0, peak_overflow}, 0);

`ifdef MAG_PEAK_THRESHOLD_EN
        threshold = 5;
        drive(1, 0, 5, 0, 32'h3, 0);
        drive(1, 0, 6, 1, 32'h3, 0);
        drive(1, 1, 10, 2, 32'h3, 0);
        idle();
        check("thr_valid", {63'd0, peak_valid}, 1);
        check("thr_above", {48'd0, above_count}, 2);
        check("thr_mag",   peak_mag, 10);
`endif

        repeat (2) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
